conv_seq_controller: RTL and testbench

- Parametrised successor to the fixed 3-tap convolution controller.
- Sequences priming, streaming and coefficient loading for a K-tap sliding-window convolution datapath, with configurable stride.
- Adds convolution counting and overrun detection.
- Sits between the host-side strobe interface and the sample shift register / coefficient bank / MAC datapath.

---
 rtl/conv_seq_controller_if.sv | 32 +++
 rtl/conv_seq_controller.sv | 138 +++++++++++++
 tb/tb_conv_seq_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_controller_if.sv
// Host strobe / datapath control bundle for the convolution sequencer.
// master drives the host strobes; slave is the controller.
interface conv_seq_controller_if #(
  parameter int unsigned KSIZE = 3,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned SEL_W = $clog2(KSIZE);

  logic             sample_load_en;
  logic             new_row;
  logic             coeff_load_en;
  logic             modwait;
  logic             sample_shift;
  logic             sample_stream;
  logic             convolve_en;
  logic             coeff_ld;
  logic [SEL_W-1:0] coeff_sel;
  logic [CNT_W-1:0] conv_count;
  logic             overrun;

  modport master (
    output sample_load_en, new_row, coeff_load_en,
    input  modwait, sample_shift, sample_stream, convolve_en,
    input  coeff_ld, coeff_sel, conv_count, overrun
  );

  modport slave (
    input  sample_load_en, new_row, coeff_load_en,
    output modwait, sample_shift, sample_stream, convolve_en,
    output coeff_ld, coeff_sel, conv_count, overrun
  );
endinterface

// File: rtl/conv_seq_controller.sv
// K-tap sliding-window convolution sequencer: window priming, strided streaming,
// coefficient bank loading, convolution counting and dropped-strobe detection.
module conv_seq_controller #(
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned SEL_W  = $clog2(KSIZE),
  parameter int unsigned CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  conv_seq_controller_if.slave bus
);

  localparam int unsigned SKIP_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [SEL_W-1:0]  LAST_TAP  = SEL_W'(KSIZE - 1);
  localparam logic [SKIP_W-1:0] LAST_SKIP = SKIP_W'(STRIDE - 1);

  typedef enum logic [2:0] {
    IDLE, PRIME_LOAD, PRIME_WAIT, CONV, STREAM_LOAD, STREAM_WAIT, COEFF_LOAD
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  prime_cnt, prime_nxt;
  logic [SEL_W-1:0]  coeff_cnt, coeff_nxt;
  logic [SKIP_W-1:0] skip_cnt, skip_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              busy_c;

  assign busy_c = (state == PRIME_LOAD) || (state == STREAM_LOAD) || (state == COEFF_LOAD);

  // Next-state and counter update; strobes seen while busy have no effect here.
  always_comb begin
    state_nxt = state;
    prime_nxt = prime_cnt;
    coeff_nxt = coeff_cnt;
    skip_nxt  = skip_cnt;
    count_nxt = bus.conv_count;
    case (state)
      IDLE: begin
        if (bus.coeff_load_en) begin
          state_nxt = COEFF_LOAD;
          coeff_nxt = '0;
          count_nxt = '0;
        end else if (bus.sample_load_en) begin
          state_nxt = PRIME_LOAD;
          prime_nxt = '0;
        end
      end
      PRIME_LOAD: begin
        if (prime_cnt == LAST_TAP) begin
          state_nxt = CONV;
        end else begin
          prime_nxt = prime_cnt + SEL_W'(1);
          state_nxt = PRIME_WAIT;
        end
      end
      PRIME_WAIT: begin
        if (bus.coeff_load_en) begin
          state_nxt = COEFF_LOAD;
          coeff_nxt = '0;
          count_nxt = '0;
          prime_nxt = '0;
        end else if (bus.sample_load_en) begin
          state_nxt = PRIME_LOAD;
          if (bus.new_row) prime_nxt = '0;
        end
      end
      CONV, STREAM_WAIT: begin
        // CONV counts the window, then behaves as a streaming wait cycle
        if (state == CONV) begin
          count_nxt = bus.conv_count + CNT_W'(1);
          skip_nxt  = '0;
        end
        if (bus.coeff_load_en) begin
          state_nxt = COEFF_LOAD;
          coeff_nxt = '0;
          count_nxt = '0;
        end else if (bus.sample_load_en && bus.new_row) begin
          state_nxt = PRIME_LOAD;
          prime_nxt = '0;
        end else if (bus.sample_load_en) begin
          state_nxt = STREAM_LOAD;
        end else begin
          state_nxt = STREAM_WAIT;
        end
      end
      STREAM_LOAD: begin
        if (skip_cnt == LAST_SKIP) begin
          state_nxt = CONV;
        end else begin
          skip_nxt  = skip_cnt + SKIP_W'(1);
          state_nxt = STREAM_WAIT;
        end
      end
      COEFF_LOAD: begin
        if (coeff_cnt == LAST_TAP) begin
          state_nxt = IDLE;
        end else begin
          coeff_nxt = coeff_cnt + SEL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and Moore outputs decoded from the next state so they land with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      prime_cnt         <= '0;
      coeff_cnt         <= '0;
      skip_cnt          <= '0;
      bus.conv_count    <= '0;
      bus.modwait       <= 1'b0;
      bus.sample_shift  <= 1'b0;
      bus.sample_stream <= 1'b0;
      bus.convolve_en   <= 1'b0;
      bus.coeff_ld      <= 1'b0;
      bus.coeff_sel     <= '0;
      bus.overrun       <= 1'b0;
    end else begin
      state             <= state_nxt;
      prime_cnt         <= prime_nxt;
      coeff_cnt         <= coeff_nxt;
      skip_cnt          <= skip_nxt;
      bus.conv_count    <= count_nxt;
      bus.modwait       <= (state_nxt == PRIME_LOAD) || (state_nxt == STREAM_LOAD) ||
                           (state_nxt == COEFF_LOAD);
      bus.sample_shift  <= (state_nxt == PRIME_LOAD) || (state_nxt == STREAM_LOAD);
      bus.sample_stream <= (state_nxt == CONV) || (state_nxt == STREAM_WAIT);
      bus.convolve_en   <= (state_nxt == CONV);
      bus.coeff_ld      <= (state_nxt == COEFF_LOAD);
      bus.coeff_sel     <= (state_nxt == COEFF_LOAD) ? coeff_nxt : '0;
      bus.overrun       <= busy_c && (bus.sample_load_en || bus.coeff_load_en);
    end
  end

endmodule

// File: tb/tb_conv_seq_controller.sv
// Bench for conv_seq_controller: a 3-tap/stride-1 and a 5-tap/stride-2 instance share
// host strobes and are compared every cycle against a window/stride occupancy model.
module tb_conv_seq_controller;

  logic clk;
  logic rst;
  logic s_in, c_in, nr_in;
  int   n_checks = 0;
  int   n_errors = 0;

  conv_seq_controller_if #(.KSIZE(3), .CNT_W(16)) if0 ();
  conv_seq_controller_if #(.KSIZE(5), .CNT_W(16)) if1 ();

  assign if0.sample_load_en = s_in;
  assign if0.coeff_load_en  = c_in;
  assign if0.new_row        = nr_in;
  assign if1.sample_load_en = s_in;
  assign if1.coeff_load_en  = c_in;
  assign if1.new_row        = nr_in;

  conv_seq_controller #(.KSIZE(3), .STRIDE(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
  conv_seq_controller #(.KSIZE(5), .STRIDE(2), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: window fill level, samples since last convolution, pending load/conv cycles.
  int m_k[2]  = '{3, 5};
  int m_s[2]  = '{1, 2};
  int coeff_left[2];
  bit shift_now[2];
  bit conv_now[2];
  bit streaming[2];
  int have[2];
  int since[2];
  int cnt[2];
  bit ovr[2];

  function automatic bit e_modwait(input int d);
    return (coeff_left[d] > 0) || shift_now[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      coeff_left[d] = 0; shift_now[d] = 0; conv_now[d] = 0; streaming[d] = 0;
      have[d] = 0; since[d] = 0; cnt[d] = 0; ovr[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit s, input bit c, input bit nr);
    bit n_ovr;
    n_ovr = e_modwait(d) && (s || c);
    if (coeff_left[d] > 0) begin
      coeff_left[d]--;
    end else if (shift_now[d]) begin
      shift_now[d] = 0;
      if (!streaming[d]) begin
        have[d]++;
        if (have[d] == m_k[d]) begin
          streaming[d] = 1;
          conv_now[d]  = 1;
        end
      end else begin
        since[d]++;
        if (since[d] == m_s[d]) conv_now[d] = 1;
      end
    end else begin
      if (conv_now[d]) begin
        cnt[d]      = (cnt[d] + 1) & 32'hFFFF;
        since[d]    = 0;
        conv_now[d] = 0;
      end
      if (c) begin
        coeff_left[d] = m_k[d];
        cnt[d] = 0; have[d] = 0; streaming[d] = 0;
      end else if (s) begin
        if (nr) begin
          streaming[d] = 0;
          have[d] = 0;
        end
        shift_now[d] = 1;
      end
    end
    ovr[d] = n_ovr;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, s_in, c_in, nr_in);
      model_step(1, s_in, c_in, nr_in);
    end
  end

  task automatic cmp(input int d, input logic mw, input logic sh, input logic ss,
                     input logic ce, input logic cl, input logic [31:0] sel,
                     input logic [31:0] cc, input logic ov);
    chk($sformatf("d%0d_modwait", d), 32'(mw), 32'(e_modwait(d)));
    chk($sformatf("d%0d_sample_shift", d), 32'(sh), 32'(shift_now[d]));
    chk($sformatf("d%0d_sample_stream", d), 32'(ss),
        32'(conv_now[d] || (streaming[d] && !shift_now[d] && coeff_left[d] == 0)));
    chk($sformatf("d%0d_convolve_en", d), 32'(ce), 32'(conv_now[d]));
    chk($sformatf("d%0d_coeff_ld", d), 32'(cl), 32'(coeff_left[d] > 0));
    chk($sformatf("d%0d_coeff_sel", d), sel,
        (coeff_left[d] > 0) ? 32'(m_k[d] - coeff_left[d]) : 32'd0);
    chk($sformatf("d%0d_conv_count", d), cc, 32'(cnt[d]));
    chk($sformatf("d%0d_overrun", d), 32'(ov), 32'(ovr[d]));
  endtask

  always @(negedge clk) begin
    cmp(0, if0.modwait, if0.sample_shift, if0.sample_stream, if0.convolve_en,
        if0.coeff_ld, 32'(if0.coeff_sel), 32'(if0.conv_count), if0.overrun);
    cmp(1, if1.modwait, if1.sample_shift, if1.sample_stream, if1.convolve_en,
        if1.coeff_ld, 32'(if1.coeff_sel), 32'(if1.conv_count), if1.overrun);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic cv0_seen, cv1_seen;

  // One isolated sample strobe; records convolve_en on the cycle after the load.
  task automatic pulse(input logic nr);
    s_in = 1'b1; nr_in = nr;
    tick();
    s_in = 1'b0; nr_in = 1'b0;
    chk("pulse_sample_shift", 32'(if0.sample_shift), 32'd1);
    tick();
    cv0_seen = if0.convolve_en;
    cv1_seen = if1.convolve_en;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; s_in = 1'b0; c_in = 1'b0; nr_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_modwait", 32'(if0.modwait), 32'd0);
    chk("rst_conv_count", 32'(if0.conv_count), 32'd0);
    rst = 1'b0;
    tick();

    // coefficient load sequencing
    c_in = 1'b1; tick(); c_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        chk("d0_coeff_ld_run", 32'(if0.coeff_ld), 32'd1);
        chk("d0_coeff_sel_run", 32'(if0.coeff_sel), 32'(i));
        chk("d0_modwait_run", 32'(if0.modwait), 32'd1);
      end
      chk("d1_coeff_sel_run", 32'(if1.coeff_sel), 32'(i));
      tick();
    end
    chk("d0_coeff_done", 32'(if0.coeff_ld), 32'd0);
    chk("d1_coeff_done", 32'(if1.modwait), 32'd0);

    // priming and streaming
    pulse(1'b0); pulse(1'b0);
    chk("d0_no_conv_early", 32'(cv0_seen), 32'd0);
    pulse(1'b0);
    chk("d0_window_conv", 32'(cv0_seen), 32'd1);
    chk("d0_count_1", 32'(if0.conv_count), 32'd1);
    for (int i = 0; i < 4; i++) pulse(1'b0);
    chk("d0_count_5", 32'(if0.conv_count), 32'd5);
    chk("d1_count_2", 32'(if1.conv_count), 32'd2);
    for (int i = 0; i < 4; i++) pulse(1'b0);
    chk("d0_count_9", 32'(if0.conv_count), 32'd9);
    chk("d1_count_4", 32'(if1.conv_count), 32'd4);

    // row restart, then a strobe dropped during PRIME_LOAD
    s_in = 1'b1; nr_in = 1'b1; tick();
    nr_in = 1'b0;
    chk("d0_restart_modwait", 32'(if0.modwait), 32'd1);
    tick();
    s_in = 1'b0;
    chk("d0_overrun", 32'(if0.overrun), 32'd1);
    chk("d1_overrun", 32'(if1.overrun), 32'd1);
    tick(); tick();
    pulse(1'b0);
    chk("d0_prime_unchanged", 32'(if0.conv_count), 32'd9);
    pulse(1'b0);
    chk("d0_count_10", 32'(if0.conv_count), 32'd10);
    chk("d1_count_still_4", 32'(if1.conv_count), 32'd4);

    // simultaneous strobes: coefficient load wins, no overrun
    s_in = 1'b1; c_in = 1'b1; tick();
    s_in = 1'b0; c_in = 1'b0;
    chk("d0_both_coeff_ld", 32'(if0.coeff_ld), 32'd1);
    chk("d0_both_count_clr", 32'(if0.conv_count), 32'd0);
    chk("d0_both_no_overrun", 32'(if0.overrun), 32'd0);
    chk("d1_both_count_clr", 32'(if1.conv_count), 32'd0);
    tick();
    chk("d0_coeff_sel_1", 32'(if0.coeff_sel), 32'd1);

    // asynchronous reset mid coefficient load
    rst = 1'b1;
    #1;
    chk("rst_mid_coeff_ld", 32'(if0.coeff_ld), 32'd0);
    chk("rst_mid_coeff_sel", 32'(if0.coeff_sel), 32'd0);
    chk("rst_mid_modwait", 32'(if0.modwait), 32'd0);
    chk("rst_mid_d1_coeff_ld", 32'(if1.coeff_ld), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    c_in = 1'b1; tick(); c_in = 1'b0;
    chk("restart_coeff_sel_0", 32'(if0.coeff_sel), 32'd0);
    chk("restart_coeff_ld", 32'(if0.coeff_ld), 32'd1);
    repeat (6) tick();

    // randomized traffic, including occasional short resets
    for (int i = 0; i < 4000; i++) begin
      s_in  = ($urandom_range(99) < 35);
      c_in  = ($urandom_range(99) < 4);
      nr_in = ($urandom_range(99) < 25);
      if ($urandom_range(599) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      tick();
    end
    s_in = 1'b0; c_in = 1'b0; nr_in = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
